// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and helpers for the multi-port register file
package regfile_pkg;

  typedef enum logic {RF_CLEAR, RF_IDLE} rf_state_t;

  // True when addr names a real, writable/readable architectural register.
  function automatic logic rf_addr_valid(input int unsigned addr,
                                         input int unsigned nregs,
                                         input logic        zero_reg);
    return (addr < nregs) && !(zero_reg && (addr == 0));
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one combinational read port with zero, range and bypass rules
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                busy,
  input  logic [AW-1:0]       ra,
  input  logic [XLEN-1:0]     rf_data,
  input  logic [NWR-1:0]      wen,
  input  logic [NWR*AW-1:0]   wa,
  input  logic [NWR*XLEN-1:0] wd,
  output logic [XLEN-1:0]     rd
);

  // wen already excludes dropped writes, so later ports simply override earlier ones
  always_comb begin
    rd = '0;
    if (!busy && rf_addr_valid(32'(ra), NREGS, ZERO_REG != 0)) begin
      rd = rf_data;
      if (BYPASS != 0) begin
        for (int i = 0; i < NWR; i++) begin
          if (wen[i] && (wa[i*AW +: AW] == ra)) rd = wd[i*XLEN +: XLEN];
        end
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-port register file with clear sequencer and bypass
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = $clog2(NREGS),
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_req,
  output logic                busy,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   wa,
  input  logic [NWR*XLEN-1:0] wd,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd
);

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  rf_state_t       state, state_nxt;
  logic [AW-1:0]   clr_cnt, clr_cnt_nxt;
  logic [XLEN-1:0] rf [NREGS];
  logic [NWR-1:0]  wen_ok;
  logic [NWR-1:0]  wen_win;

  assign busy = (state == RF_CLEAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RF_CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      RF_CLEAR: begin
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == LAST) begin
          state_nxt   = RF_IDLE;
          clr_cnt_nxt = '0;
        end
      end
      RF_IDLE: begin
        if (clr_req) begin
          state_nxt   = RF_CLEAR;
          clr_cnt_nxt = '0;
        end
      end
    endcase
  end

  // A port only commits if no higher-indexed live port hits the same register
  for (genvar i = 0; i < NWR; i++) begin : g_wr
    logic shadowed;
    assign wen_ok[i] = !busy && we[i] &&
                       rf_addr_valid(32'(wa[i*AW +: AW]), NREGS, ZERO_REG != 0);
    always_comb begin
      shadowed = 1'b0;
      for (int j = i + 1; j < NWR; j++) begin
        if (wen_ok[j] && (wa[j*AW +: AW] == wa[i*AW +: AW])) shadowed = 1'b1;
      end
    end
    assign wen_win[i] = wen_ok[i] && !shadowed;
  end

  // Unreset storage; the sweep and the write ports share this single write path
  always_ff @(posedge clk) begin
    if (busy) begin
      rf[clr_cnt] <= '0;
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (wen_win[i]) rf[wa[i*AW +: AW]] <= wd[i*XLEN +: XLEN];
      end
    end
  end

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    logic [AW-1:0]   ra_j;
    logic [XLEN-1:0] rf_data;
    assign ra_j    = ra[j*AW +: AW];
    assign rf_data = (32'(ra_j) < NREGS) ? rf[ra_j] : '0;

    regfile_read_port #(
      .XLEN     (XLEN),
      .NREGS    (NREGS),
      .AW       (AW),
      .NWR      (NWR),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_read_port (
      .busy    (busy),
      .ra      (ra_j),
      .rf_data (rf_data),
      .wen     (wen_ok),
      .wa      (wa),
      .wd      (wd),
      .rd      (rd[j*XLEN +: XLEN])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  logic        d_clr, d_busy, d_we;
  logic [4:0]  d_wa;
  logic [31:0] d_wd;
  logic [9:0]  d_ra;
  logic [63:0] d_rd;

  logic        n_clr, n_busy, n_we;
  logic [4:0]  n_wa;
  logic [31:0] n_wd;
  logic [9:0]  n_ra;
  logic [63:0] n_rd;

  logic        w_clr, w_busy;
  logic [1:0]  w_we;
  logic [9:0]  w_wa;
  logic [63:0] w_wd;
  logic [9:0]  w_ra;
  logic [63:0] w_rd;

  logic        r_clr, r_busy, r_we;
  logic [4:0]  r_wa;
  logic [31:0] r_wd;
  logic [14:0] r_ra;
  logic [95:0] r_rd;

  regfile_mp u_def (
    .clk(clk), .rst_n(rst_n), .clr_req(d_clr), .busy(d_busy),
    .we(d_we), .wa(d_wa), .wd(d_wd), .ra(d_ra), .rd(d_rd)
  );

  regfile_mp #(.BYPASS(0)) u_nb (
    .clk(clk), .rst_n(rst_n), .clr_req(n_clr), .busy(n_busy),
    .we(n_we), .wa(n_wa), .wd(n_wd), .ra(n_ra), .rd(n_rd)
  );

  regfile_mp #(.NWR(2)) u_w2 (
    .clk(clk), .rst_n(rst_n), .clr_req(w_clr), .busy(w_busy),
    .we(w_we), .wa(w_wa), .wd(w_wd), .ra(w_ra), .rd(w_rd)
  );

  regfile_mp #(.NREGS(24), .NRD(3)) u_r24 (
    .clk(clk), .rst_n(rst_n), .clr_req(r_clr), .busy(r_busy),
    .we(r_we), .wa(r_wa), .wd(r_wd), .ra(r_ra), .rd(r_rd)
  );

  task test_reset;
    @(negedge clk);
    rst_n = 1'b0;
    d_we = 1'b1; d_wa = 5'd5; d_wd = 32'hDEAD; d_ra = {5'd0, 5'd5};
    #1;
    total++;
    if (d_busy !== 1'b1 || d_rd !== 64'h0) begin
      bad++; $display("FAIL reset_hold busy=%b rd=%h exp busy=1 rd=0", d_busy, d_rd);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      #1;
      total++;
      if (d_busy !== 1'b1) begin
        bad++; $display("FAIL reset_sweep_busy cyc=%0d got=%b exp=1", i, d_busy);
      end
      total++;
      if (d_rd[31:0] !== 32'h0) begin
        bad++; $display("FAIL reset_sweep_rd cyc=%0d got=%h exp=0", i, d_rd[31:0]);
      end
      @(negedge clk);
    end
    d_we = 1'b0;
    #1;
    total++;
    if (d_busy !== 1'b0) begin
      bad++; $display("FAIL reset_done_busy got=%b exp=0", d_busy);
    end
    total++;
    if (d_rd[31:0] !== 32'h0) begin
      bad++; $display("FAIL reset_lost_write got=%h exp=0", d_rd[31:0]);
    end
    repeat (4) @(negedge clk);
  endtask

  task test_bypass;
    @(negedge clk);
    d_we = 1'b1; d_wa = 5'd7; d_wd = 32'h1234; d_ra = {5'd0, 5'd7};
    #1;
    total++;
    if (d_rd[31:0] !== 32'h1234) begin
      bad++; $display("FAIL bypass_same got=%h exp=1234", d_rd[31:0]);
    end
    total++;
    if (d_rd[63:32] !== 32'h0) begin
      bad++; $display("FAIL zero_reg_read got=%h exp=0", d_rd[63:32]);
    end
    @(negedge clk);
    d_we = 1'b0;
    #1;
    total++;
    if (d_rd[31:0] !== 32'h1234) begin
      bad++; $display("FAIL bypass_stored got=%h exp=1234", d_rd[31:0]);
    end

    @(negedge clk);
    n_we = 1'b1; n_wa = 5'd7; n_wd = 32'h5555; n_ra = {5'd0, 5'd7};
    #1;
    total++;
    if (n_rd[31:0] !== 32'h0) begin
      bad++; $display("FAIL nobyp_cleared got=%h exp=0", n_rd[31:0]);
    end
    @(negedge clk);
    n_wd = 32'h1234;
    #1;
    total++;
    if (n_rd[31:0] !== 32'h5555) begin
      bad++; $display("FAIL nobyp_old got=%h exp=5555", n_rd[31:0]);
    end
    @(negedge clk);
    n_we = 1'b0;
    #1;
    total++;
    if (n_rd[31:0] !== 32'h1234) begin
      bad++; $display("FAIL nobyp_next got=%h exp=1234", n_rd[31:0]);
    end
  endtask

  task test_conflict;
    @(negedge clk);
    w_we = 2'b11; w_wa = {5'd3, 5'd3}; w_wd = {32'hBBBB, 32'hAAAA}; w_ra = {5'd0, 5'd3};
    #1;
    total++;
    if (w_rd[31:0] !== 32'hBBBB) begin
      bad++; $display("FAIL conflict_bypass got=%h exp=bbbb", w_rd[31:0]);
    end
    @(negedge clk);
    w_we = 2'b00;
    #1;
    total++;
    if (w_rd[31:0] !== 32'hBBBB) begin
      bad++; $display("FAIL conflict_stored got=%h exp=bbbb", w_rd[31:0]);
    end
    @(negedge clk);
    w_we = 2'b01; w_wa = {5'd0, 5'd0}; w_wd = {32'h0, 32'hFFFF}; w_ra = {5'd0, 5'd0};
    #1;
    total++;
    if (w_rd[31:0] !== 32'h0) begin
      bad++; $display("FAIL zero_write_same got=%h exp=0", w_rd[31:0]);
    end
    @(negedge clk);
    w_we = 2'b11; w_wa = {5'd6, 5'd4}; w_wd = {32'h6666, 32'h4444}; w_ra = {5'd6, 5'd4};
    #1;
    total++;
    if (w_rd !== {32'h6666, 32'h4444}) begin
      bad++; $display("FAIL split_bypass got=%h exp=0000666600004444", w_rd);
    end
    @(negedge clk);
    w_we = 2'b00; w_ra = {5'd6, 5'd0};
    #1;
    total++;
    if (w_rd[31:0] !== 32'h0) begin
      bad++; $display("FAIL zero_write_next got=%h exp=0", w_rd[31:0]);
    end
    total++;
    if (w_rd[63:32] !== 32'h6666) begin
      bad++; $display("FAIL split_port1 got=%h exp=6666", w_rd[63:32]);
    end
  endtask

  task test_range;
    @(negedge clk);
    r_we = 1'b1; r_wa = 5'd30; r_wd = 32'hCAFE; r_ra = {5'd30, 5'd30, 5'd30};
    #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (r_rd[k*32 +: 32] !== 32'h0) begin
        bad++; $display("FAIL range_same port=%0d got=%h exp=0", k, r_rd[k*32 +: 32]);
      end
    end
    @(negedge clk);
    r_wa = 5'd23; r_wd = 32'h2323;
    #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (r_rd[k*32 +: 32] !== 32'h0) begin
        bad++; $display("FAIL range_next port=%0d got=%h exp=0", k, r_rd[k*32 +: 32]);
      end
    end
    @(negedge clk);
    r_we = 1'b0; r_ra = {5'd30, 5'd23, 5'd30};
    #1;
    total++;
    if (r_rd !== {32'h0, 32'h2323, 32'h0}) begin
      bad++; $display("FAIL range_last got=%h exp=000000000000232300000000", r_rd);
    end
  endtask

  task test_clear;
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      d_we = 1'b1; d_wa = 5'(i); d_wd = 32'(i);
    end
    @(negedge clk);
    d_we = 1'b0; d_ra = {5'd31, 5'd1};
    #1;
    total++;
    if (d_rd !== {32'd31, 32'd1}) begin
      bad++; $display("FAIL fill got=%h exp=0000001f00000001", d_rd);
    end
    @(negedge clk);
    d_clr = 1'b1;
    #1;
    total++;
    if (d_busy !== 1'b0) begin
      bad++; $display("FAIL clr_pre got=%b exp=0", d_busy);
    end
    @(negedge clk);
    d_clr = 1'b0;
    for (int i = 0; i < 32; i++) begin
      #1;
      total++;
      if (d_busy !== 1'b1) begin
        bad++; $display("FAIL clr_busy cyc=%0d got=%b exp=1", i, d_busy);
      end
      d_clr = (i == 10);
      @(negedge clk);
    end
    d_clr = 1'b0;
    #1;
    total++;
    if (d_busy !== 1'b0) begin
      bad++; $display("FAIL clr_done got=%b exp=0", d_busy);
    end
    for (int r = 0; r < 32; r += 2) begin
      d_ra = {5'(r + 1), 5'(r)};
      #1;
      total++;
      if (d_rd !== 64'h0) begin
        bad++; $display("FAIL clr_zero reg=%0d got=%h exp=0", r, d_rd);
      end
      @(negedge clk);
    end
  endtask

  task test_reset_mid;
    @(negedge clk);
    d_clr = 1'b1;
    @(negedge clk);
    d_clr = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (d_busy !== 1'b1 || d_rd !== 64'h0) begin
      bad++; $display("FAIL rst_mid_low busy=%b rd=%h exp busy=1 rd=0", d_busy, d_rd);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      #1;
      total++;
      if (d_busy !== 1'b1) begin
        bad++; $display("FAIL rst_mid_busy cyc=%0d got=%b exp=1", i, d_busy);
      end
      @(negedge clk);
    end
    #1;
    total++;
    if (d_busy !== 1'b0) begin
      bad++; $display("FAIL rst_mid_done got=%b exp=0", d_busy);
    end
  endtask

  initial begin
    d_clr = 1'b0; d_we = 1'b0; d_wa = '0; d_wd = '0; d_ra = '0;
    n_clr = 1'b0; n_we = 1'b0; n_wa = '0; n_wd = '0; n_ra = '0;
    w_clr = 1'b0; w_we = '0;   w_wa = '0; w_wd = '0; w_ra = '0;
    r_clr = 1'b0; r_we = 1'b0; r_wa = '0; r_wd = '0; r_ra = '0;
    test_reset();
    test_bypass();
    test_conflict();
    test_range();
    test_clear();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
